reset_release_sequencer: RTL and testbench

Controller that orders deassertion of the per-domain reset synchronizer chains. Each domain's chain produces a synchronized reset whose release the domain reports back as an acknowledge. After global reset or a software re-reset request, the block holds every domain in reset and releases them one at a time, lowest index first. It waits for each domain's acknowledge, then inserts a fixed settling gap before the next release. It sits beside the clock/reset crossing logic in the always-on region and is the only source of the domain reset enables.

---
 rtl/reset_release_sequencer.sv | 138 +++++++++++++
 tb/tb_reset_release_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_release_sequencer.sv
// Orders deassertion of per-domain reset enables: hold all domains, then release
// them one at a time, lowest index first, waiting for each acknowledge plus a settling gap.
module reset_release_sequencer #(
   parameter int N_DOMAINS      = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int HOLD_CYCLES    = 4,
   parameter int GAP_CYCLES     = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 req_rereset,
   input  logic [N_DOMAINS-1:0] dom_ack,
   output logic [N_DOMAINS-1:0] dom_reset_n,
   output logic                 busy,
   output logic                 seq_done,
   output logic                 timeout_err
);

   localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int MAX_T  = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
   localparam int CNT_W  = $clog2(MAX_T + 1);
   localparam int IDX_W  = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(N_DOMAINS - 1);

   typedef enum logic [2:0] {
      S_HOLD,
      S_RELEASE,
      S_WAIT_ACK,
      S_GAP,
      S_DONE
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     idx;
   logic [N_DOMAINS-1:0] sync_q [SYNC_STAGES];
   logic [N_DOMAINS-1:0] ack_s;

   // NOTE: synchronizer flops are individually reset so a stale acknowledge
   // cannot survive a reset and shortcut the first WAIT_ACK.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= dom_ack;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign ack_s = sync_q[SYNC_STAGES-1];

   // NOTE: all state and outputs use non-blocking assignments so every branch
   // below reads the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_HOLD;
         cnt         <= '0;
         idx         <= '0;
         dom_reset_n <= '0;
         busy        <= 1'b1;
         seq_done    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state <= S_RELEASE;
                  cnt   <= '0;
                  idx   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_RELEASE: begin
               dom_reset_n[idx] <= 1'b1;
               state            <= S_WAIT_ACK;
               cnt              <= '0;
            end

            // An acknowledge on the final timeout cycle wins over the timeout.
            S_WAIT_ACK: begin
               if (ack_s[idx] || (cnt == TIMEOUT_LAST)) begin
                  if (!ack_s[idx]) timeout_err <= 1'b1;
                  cnt <= '0;
                  if (idx == IDX_LAST) begin
                     state    <= S_DONE;
                     busy     <= 1'b0;
                     seq_done <= 1'b1;
                  end else begin
                     state <= S_GAP;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  idx   <= idx + 1'b1;
                  state <= S_RELEASE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            S_DONE: begin
               if (req_rereset) begin
                  state       <= S_HOLD;
                  cnt         <= '0;
                  idx         <= '0;
                  dom_reset_n <= '0;
                  busy        <= 1'b1;
                  seq_done    <= 1'b0;
                  timeout_err <= 1'b0;
               end
            end

            default: begin
               state       <= S_HOLD;
               cnt         <= '0;
               idx         <= '0;
               dom_reset_n <= '0;
               busy        <= 1'b1;
               seq_done    <= 1'b0;
               timeout_err <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench: a schedule model computes release/done/timeout edges
// arithmetically from the acknowledge stimulus; outputs are compared every cycle.
`timescale 1ns/1ps
module tb_reset_release_sequencer;

   localparam int N      = 4;
   localparam int SYNC   = 2;
   localparam int HOLD   = 4;
   localparam int GAP    = 8;
   localparam int TMO    = 64;
   localparam int INF    = 1 << 30;
   localparam int NEVER  = -1;
   localparam int ALWAYS = -2;

   logic         clock       = 1'b0;
   logic         reset_n     = 1'b0;
   logic         req_rereset = 1'b0;
   logic [N-1:0] dom_ack     = '0;
   logic [N-1:0] dom_reset_n;
   logic         busy;
   logic         seq_done;
   logic         timeout_err;

   int cyc         = 0;
   int vectors     = 0;
   int miscompares = 0;
   int start_e     = INF;
   int done_e      = INF;
   int terr_e      = INF;
   int rel     [N];
   int ack_dly [N];

   reset_release_sequencer #(
      .N_DOMAINS      (N),
      .SYNC_STAGES    (SYNC),
      .HOLD_CYCLES    (HOLD),
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_rereset (req_rereset),
      .dom_ack     (dom_ack),
      .dom_reset_n (dom_reset_n),
      .busy        (busy),
      .seq_done    (seq_done),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Edge number relative to the sequence start (start edge = edge 1).
   function automatic int rel_edge(input int e);
      return e - start_e + 1;
   endfunction

   // Schedule model: edges (absolute cycle counts) at which each domain is
   // released, the sequence finishes, and timeout_err first rises.
   // An ack driven right after edge e is acted on at edge e+1+SYNC.
   task automatic plan(input int s);
      int x;
      x       = 0;
      start_e = s;
      terr_e  = INF;
      for (int i = 0; i < N; i++) begin
         rel[i] = (i == 0) ? s + HOLD : x + GAP + 1;
         if (ack_dly[i] == ALWAYS)     x = rel[i] + 1;
         else if (ack_dly[i] == NEVER) x = INF;
         else                          x = rel[i] + ack_dly[i] + 1 + SYNC;
         if (x > rel[i] + TMO) begin
            x = rel[i] + TMO;
            if (terr_e == INF) terr_e = x;
         end
      end
      done_e = x;
   endtask

   task automatic drive_acks();
      for (int i = 0; i < N; i++) begin
         if (ack_dly[i] == ALWAYS)     dom_ack[i] = 1'b1;
         else if (ack_dly[i] == NEVER) dom_ack[i] = 1'b0;
         else                          dom_ack[i] = (cyc >= rel[i] + ack_dly[i]);
      end
   endtask

   task automatic step();
      @(posedge clock);
      cyc++;
      #1;
      drive_acks();
   endtask

   task automatic run_to(input int e);
      while (cyc < e) step();
   endtask

   task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
      ack_dly[0] = d0;
      ack_dly[1] = d1;
      ack_dly[2] = d2;
      ack_dly[3] = d3;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (3) step();
      @(negedge clock);
      #1;
      reset_n = 1'b1;
      plan(cyc + 1);
      drive_acks();
   endtask

   // Compare process: every cycle, outputs against the schedule model.
   always @(negedge clock) begin
      logic [N+2:0] exp;
      exp = '0;
      if (!reset_n) begin
         exp[2] = 1'b1;
      end else begin
         for (int i = 0; i < N; i++) exp[i+3] = (cyc >= rel[i]);
         exp[2] = (cyc < done_e);
         exp[1] = (cyc >= done_e);
         exp[0] = (cyc >= terr_e);
      end
      check($sformatf("cycle %0d {dom_reset_n,busy,seq_done,timeout_err}", cyc),
            int'({dom_reset_n, busy, seq_done, timeout_err}), int'(exp));
   end

   initial begin
      for (int i = 0; i < N; i++) rel[i] = INF;

      // Nominal: each ack 3 cycles after its release; stray re-reset in GAP.
      set_dly(3, 3, 3, 3);
      apply_reset();
      check("nom rel0 edge", rel_edge(rel[0]), 5);
      check("nom rel1 edge", rel_edge(rel[1]), 20);
      check("nom rel3 edge", rel_edge(rel[3]), 50);
      check("nom done edge", rel_edge(done_e), 56);
      check("nom no timeout", terr_e, INF);
      run_to(start_e + 13);
      req_rereset = 1'b1;
      step();
      req_rereset = 1'b0;
      run_to(done_e + 4);

      // Timeout on domain 1, then re-reset from DONE with nominal acks.
      set_dly(3, NEVER, 3, 3);
      apply_reset();
      check("tmo terr edge", rel_edge(terr_e), 84);
      check("tmo rel2 edge", rel_edge(rel[2]), 93);
      check("tmo done edge", rel_edge(done_e), 114);
      run_to(done_e + 4);
      set_dly(3, 3, 3, 3);
      req_rereset = 1'b1;
      step();
      req_rereset = 1'b0;
      plan(cyc + 1);
      drive_acks();
      check("rerst rel0 edge", rel_edge(rel[0]), 5);
      check("rerst done edge", rel_edge(done_e), 56);
      run_to(done_e + 4);

      // Early acknowledges: every ack high from before reset release.
      set_dly(ALWAYS, ALWAYS, ALWAYS, ALWAYS);
      apply_reset();
      check("early rel1 edge", rel_edge(rel[1]), 15);
      check("early rel3 edge", rel_edge(rel[3]), 35);
      check("early done edge", rel_edge(done_e), 36);
      run_to(done_e + 4);

      // Acknowledge on the last timeout cycle of domain 0.
      set_dly(61, 3, 3, 3);
      apply_reset();
      check("coll rel1 edge", rel_edge(rel[1]), 78);
      check("coll no timeout", terr_e, INF);
      run_to(done_e + 4);

      // Asynchronous reset while domain 2 waits for its acknowledge.
      set_dly(3, 3, 3, 3);
      apply_reset();
      run_to(start_e + 36);
      check("pre-drop dom_reset_n", int'(dom_reset_n), 'b0111);
      #2;
      reset_n = 1'b0;
      #1;
      check("async drop outputs", int'({dom_reset_n, busy, seq_done, timeout_err}), 'b0000_100);
      apply_reset();
      check("restart rel0 edge", rel_edge(rel[0]), 5);
      run_to(done_e + 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
